// File: rtl/owmc_load_initiator_if.sv
// Handshake bundle between the load initiator, the host command port and the
// weight memory controller / PE array.
interface owmc_load_initiator_if #(
    parameter int GROUP_W = 4
);
    logic               OWMC_LOAD_INITIATOR_Cmd_Start;
    logic [GROUP_W-1:0] OWMC_LOAD_INITIATOR_Cmd_Num_Groups;
    logic               OWMC_LOAD_INITIATOR_Cmd_Skip_Weights;
    logic               OWMC_LOAD_INITIATOR_Err_Clear;
    logic               OWMC_LOAD_INITIATOR_Loading_Weights_Already;
    logic               OWMC_LOAD_INITIATOR_Loading_Regs_Already;
    logic               OWMC_LOAD_INITIATOR_Compute_Done;
    logic               OWMC_LOAD_INITIATOR_Start_Loading_Weights;
    logic               OWMC_LOAD_INITIATOR_Start_Loading_Regs;
    logic               OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok;
    logic               OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok;
    logic               OWMC_LOAD_INITIATOR_Compute_Start;
    logic               OWMC_LOAD_INITIATOR_Busy;
    logic               OWMC_LOAD_INITIATOR_Done;
    logic               OWMC_LOAD_INITIATOR_Error;
    logic [GROUP_W-1:0] OWMC_LOAD_INITIATOR_Group_Index;

    modport master (
        input  OWMC_LOAD_INITIATOR_Cmd_Start,
        input  OWMC_LOAD_INITIATOR_Cmd_Num_Groups,
        input  OWMC_LOAD_INITIATOR_Cmd_Skip_Weights,
        input  OWMC_LOAD_INITIATOR_Err_Clear,
        input  OWMC_LOAD_INITIATOR_Loading_Weights_Already,
        input  OWMC_LOAD_INITIATOR_Loading_Regs_Already,
        input  OWMC_LOAD_INITIATOR_Compute_Done,
        output OWMC_LOAD_INITIATOR_Start_Loading_Weights,
        output OWMC_LOAD_INITIATOR_Start_Loading_Regs,
        output OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok,
        output OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok,
        output OWMC_LOAD_INITIATOR_Compute_Start,
        output OWMC_LOAD_INITIATOR_Busy,
        output OWMC_LOAD_INITIATOR_Done,
        output OWMC_LOAD_INITIATOR_Error,
        output OWMC_LOAD_INITIATOR_Group_Index
    );

    modport slave (
        output OWMC_LOAD_INITIATOR_Cmd_Start,
        output OWMC_LOAD_INITIATOR_Cmd_Num_Groups,
        output OWMC_LOAD_INITIATOR_Cmd_Skip_Weights,
        output OWMC_LOAD_INITIATOR_Err_Clear,
        output OWMC_LOAD_INITIATOR_Loading_Weights_Already,
        output OWMC_LOAD_INITIATOR_Loading_Regs_Already,
        output OWMC_LOAD_INITIATOR_Compute_Done,
        input  OWMC_LOAD_INITIATOR_Start_Loading_Weights,
        input  OWMC_LOAD_INITIATOR_Start_Loading_Regs,
        input  OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok,
        input  OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok,
        input  OWMC_LOAD_INITIATOR_Compute_Start,
        input  OWMC_LOAD_INITIATOR_Busy,
        input  OWMC_LOAD_INITIATOR_Done,
        input  OWMC_LOAD_INITIATOR_Error,
        input  OWMC_LOAD_INITIATOR_Group_Index
    );
endinterface

// File: rtl/owmc_load_initiator.sv
// Initiator FSM: one bulk weight load, then per group a register load followed
// by a compute pass, with a watchdog on every controller handshake wait.
module owmc_load_initiator #(
    parameter int GROUP_W        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_W          = 11
) (
    input  logic                  OWMC_LOAD_INITIATOR_Clk,
    input  logic                  OWMC_LOAD_INITIATOR_Reset,
    owmc_load_initiator_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_REQ_W     = 4'd1,
        ST_ACK_W     = 4'd2,
        ST_REQ_R     = 4'd3,
        ST_ACK_R     = 4'd4,
        ST_CMP_PULSE = 4'd5,
        ST_CMP_WAIT  = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERROR     = 4'd8
    } state_t;

    // Output vector order: {start_w, start_r, ok_w, ok_r, compute_start, busy, done, error}
    function automatic logic [7:0] decode_outputs(input state_t st);
        logic [7:0] o;
        o = 8'b0000_0000;
        case (st)
            ST_IDLE:      o = 8'b0000_0000;
            ST_REQ_W:     o = 8'b1000_0100;
            ST_ACK_W:     o = 8'b0010_0100;
            ST_REQ_R:     o = 8'b0100_0100;
            ST_ACK_R:     o = 8'b0001_0100;
            ST_CMP_PULSE: o = 8'b0000_1100;
            ST_CMP_WAIT:  o = 8'b0000_0100;
            ST_DONE:      o = 8'b0000_0110;
            ST_ERROR:     o = 8'b0000_0001;
            default:      o = 8'b0000_0000;
        endcase
        return o;
    endfunction

    function automatic logic is_wait_state(input state_t st);
        logic w;
        case (st)
            ST_REQ_W, ST_ACK_W, ST_REQ_R, ST_ACK_R: w = 1'b1;
            default:                                w = 1'b0;
        endcase
        return w;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [7:0]         outs_r;
    logic [TMO_W-1:0]   wdog_r;
    logic [TMO_W-1:0]   wdog_nxt_s;
    logic [GROUP_W-1:0] cnt_r;
    logic [GROUP_W-1:0] cnt_nxt_s;
    logic [GROUP_W-1:0] gi_r;
    logic [GROUP_W-1:0] gi_nxt_s;
    logic               tmo_s;
    logic               last_group_s;

    assign tmo_s        = (wdog_r == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_group_s = (gi_r == (cnt_r - GROUP_W'(1)));

    // Next-state, group index and latched-count decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        gi_nxt_s    = gi_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.OWMC_LOAD_INITIATOR_Cmd_Start) begin
                    cnt_nxt_s = bus.OWMC_LOAD_INITIATOR_Cmd_Num_Groups;
                    gi_nxt_s  = {GROUP_W{1'b0}};
                    if (!bus.OWMC_LOAD_INITIATOR_Cmd_Skip_Weights) begin
                        state_nxt_s = ST_REQ_W;
                    end else if (bus.OWMC_LOAD_INITIATOR_Cmd_Num_Groups == {GROUP_W{1'b0}}) begin
                        // Nothing resident to load and nothing to compute
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_REQ_R;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ_W: begin
                if (bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already) begin
                    state_nxt_s = ST_ACK_W;
                end else if (tmo_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_REQ_W;
                end
            end
            ST_ACK_W: begin
                if (!bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already) begin
                    state_nxt_s = (cnt_r == {GROUP_W{1'b0}}) ? ST_DONE : ST_REQ_R;
                end else if (tmo_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_ACK_W;
                end
            end
            ST_REQ_R: begin
                if (bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already) begin
                    state_nxt_s = ST_ACK_R;
                end else if (tmo_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_REQ_R;
                end
            end
            ST_ACK_R: begin
                if (!bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already) begin
                    state_nxt_s = ST_CMP_PULSE;
                end else if (tmo_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_ACK_R;
                end
            end
            ST_CMP_PULSE: begin
                state_nxt_s = ST_CMP_WAIT;
            end
            ST_CMP_WAIT: begin
                if (bus.OWMC_LOAD_INITIATOR_Compute_Done) begin
                    if (last_group_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        gi_nxt_s    = gi_r + GROUP_W'(1);
                        state_nxt_s = ST_REQ_R;
                    end
                end else begin
                    state_nxt_s = ST_CMP_WAIT;
                end
            end
            ST_DONE: begin
                gi_nxt_s    = {GROUP_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
            ST_ERROR: begin
                if (bus.OWMC_LOAD_INITIATOR_Err_Clear) begin
                    gi_nxt_s    = {GROUP_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            default: begin
                gi_nxt_s    = {GROUP_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Watchdog restarts on every state entry and only runs while waiting on the controller
    always_comb begin
        if (state_nxt_s != state_r) begin
            wdog_nxt_s = {TMO_W{1'b0}};
        end else if (is_wait_state(state_r)) begin
            wdog_nxt_s = wdog_r + TMO_W'(1);
        end else begin
            wdog_nxt_s = wdog_r;
        end
    end

    // State, watchdog, group registers and outputs pre-decoded from the next state
    always_ff @(posedge OWMC_LOAD_INITIATOR_Clk or posedge OWMC_LOAD_INITIATOR_Reset) begin
        if (OWMC_LOAD_INITIATOR_Reset) begin
            state_r <= ST_IDLE;
            outs_r  <= 8'b0000_0000;
            wdog_r  <= {TMO_W{1'b0}};
            cnt_r   <= {GROUP_W{1'b0}};
            gi_r    <= {GROUP_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            outs_r  <= decode_outputs(state_nxt_s);
            wdog_r  <= wdog_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gi_r    <= gi_nxt_s;
        end
    end

    assign bus.OWMC_LOAD_INITIATOR_Start_Loading_Weights      = outs_r[7];
    assign bus.OWMC_LOAD_INITIATOR_Start_Loading_Regs         = outs_r[6];
    assign bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok = outs_r[5];
    assign bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok    = outs_r[4];
    assign bus.OWMC_LOAD_INITIATOR_Compute_Start              = outs_r[3];
    assign bus.OWMC_LOAD_INITIATOR_Busy                       = outs_r[2];
    assign bus.OWMC_LOAD_INITIATOR_Done                       = outs_r[1];
    assign bus.OWMC_LOAD_INITIATOR_Error                      = outs_r[0];
    assign bus.OWMC_LOAD_INITIATOR_Group_Index                = gi_r;

endmodule

// File: tb/tb_owmc_load_initiator.sv
// Directed bench for owmc_load_initiator: full, skip, zero-group, four-phase,
// timeout and disturbance sequences against hand-derived expectations.
module tb_owmc_load_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   viol_cnt = 0;
    int   done_cnt = 0;
    int   ev_q[$];
    logic [4:0] prev_ev = 5'd0;
    logic [4:0] cur_ev;

    always #5 clk = ~clk;

    owmc_load_initiator_if #(.GROUP_W(4)) bus ();

    owmc_load_initiator #(
        .GROUP_W(4),
        .TIMEOUT_CYCLES(8),
        .TMO_W(4)
    ) dut (
        .OWMC_LOAD_INITIATOR_Clk(clk),
        .OWMC_LOAD_INITIATOR_Reset(rst),
        .bus(bus)
    );

    // {start_w, start_r, ok_w, ok_r, compute_start, busy, done, error}
    function automatic logic [7:0] outs();
        return {bus.OWMC_LOAD_INITIATOR_Start_Loading_Weights,
                bus.OWMC_LOAD_INITIATOR_Start_Loading_Regs,
                bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok,
                bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok,
                bus.OWMC_LOAD_INITIATOR_Compute_Start,
                bus.OWMC_LOAD_INITIATOR_Busy,
                bus.OWMC_LOAD_INITIATOR_Done,
                bus.OWMC_LOAD_INITIATOR_Error};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            1: return bus.OWMC_LOAD_INITIATOR_Start_Loading_Weights;
            2: return bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok;
            3: return bus.OWMC_LOAD_INITIATOR_Start_Loading_Regs;
            4: return bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok;
            5: return bus.OWMC_LOAD_INITIATOR_Compute_Start;
            6: return bus.OWMC_LOAD_INITIATOR_Done;
            default: return 1'b0;
        endcase
    endfunction

    // Log rising edges of request/confirm/compute outputs (codes 1..5) and watch exclusivity
    always @(negedge clk) begin
        cur_ev = {bus.OWMC_LOAD_INITIATOR_Start_Loading_Weights,
                  bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok,
                  bus.OWMC_LOAD_INITIATOR_Start_Loading_Regs,
                  bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok,
                  bus.OWMC_LOAD_INITIATOR_Compute_Start};
        for (int k = 0; k < 5; k++) begin
            if (cur_ev[4-k] && !prev_ev[4-k]) ev_q.push_back(k + 1);
        end
        prev_ev = cur_ev;
        if ((cur_ev[4] && cur_ev[3]) || (cur_ev[2] && cur_ev[1]) || (cur_ev[4] && cur_ev[2]))
            viol_cnt++;
        if (bus.OWMC_LOAD_INITIATOR_Done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int sel, input int limit, input string tag);
        int n;
        n = 0;
        while (!sig(sel) && n < limit) begin
            tick();
            n++;
        end
        check(tag, {31'd0, sig(sel)}, 32'd1);
    endtask

    task automatic cmd(input logic [3:0] num, input logic skip);
        bus.OWMC_LOAD_INITIATOR_Cmd_Num_Groups   = num;
        bus.OWMC_LOAD_INITIATOR_Cmd_Skip_Weights = skip;
        bus.OWMC_LOAD_INITIATOR_Cmd_Start        = 1'b1;
        tick();
        bus.OWMC_LOAD_INITIATOR_Cmd_Start        = 1'b0;
    endtask

    // Controller model: raise Already 3 cycles after the request, drop it 1 cycle after Ok
    task automatic serve_w();
        wait_for(1, 10, "req_w");
        tick();
        tick();
        bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already = 1'b1;
        wait_for(2, 10, "ok_w");
        check("w_req_ok_excl", {31'd0, bus.OWMC_LOAD_INITIATOR_Start_Loading_Weights}, 32'd0);
        tick();
        bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already = 1'b0;
    endtask

    task automatic serve_r();
        wait_for(3, 10, "req_r");
        tick();
        tick();
        bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already = 1'b1;
        wait_for(4, 10, "ok_r");
        check("r_req_ok_excl", {31'd0, bus.OWMC_LOAD_INITIATOR_Start_Loading_Regs}, 32'd0);
        tick();
        bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already = 1'b0;
    endtask

    task automatic compute();
        wait_for(5, 10, "cmp_start");
        tick();
        bus.OWMC_LOAD_INITIATOR_Compute_Done = 1'b1;
        tick();
        bus.OWMC_LOAD_INITIATOR_Compute_Done = 1'b0;
    endtask

    // Pack logged event codes from index 'from' as octal digits, oldest first
    function automatic logic [31:0] pack_ev(input int from);
        logic [31:0] p;
        p = 32'd0;
        for (int i = from; i < ev_q.size(); i++) p = (p << 3) | 32'(ev_q[i]);
        return p;
    endfunction

    initial begin
        int ev0;
        int dn0;
        bus.OWMC_LOAD_INITIATOR_Cmd_Start                = 1'b0;
        bus.OWMC_LOAD_INITIATOR_Cmd_Num_Groups           = 4'd0;
        bus.OWMC_LOAD_INITIATOR_Cmd_Skip_Weights         = 1'b0;
        bus.OWMC_LOAD_INITIATOR_Err_Clear                = 1'b0;
        bus.OWMC_LOAD_INITIATOR_Loading_Weights_Already  = 1'b0;
        bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already     = 1'b0;
        bus.OWMC_LOAD_INITIATOR_Compute_Done             = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_outs", {24'd0, outs()}, 32'h00);
        check("reset_gi", {28'd0, bus.OWMC_LOAD_INITIATOR_Group_Index}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_outs", {24'd0, outs()}, 32'h00);

        // Full sequence, 2 groups, with a stray Cmd_Start mid-run
        ev0 = ev_q.size();
        dn0 = done_cnt;
        cmd(4'd2, 1'b0);
        check("reqw_outs", {24'd0, outs()}, 32'h84);
        serve_w();
        bus.OWMC_LOAD_INITIATOR_Cmd_Num_Groups = 4'd5;
        bus.OWMC_LOAD_INITIATOR_Cmd_Start      = 1'b1;
        tick();
        bus.OWMC_LOAD_INITIATOR_Cmd_Start      = 1'b0;
        wait_for(3, 10, "req_r_g0");
        check("gi_g0", {28'd0, bus.OWMC_LOAD_INITIATOR_Group_Index}, 32'd0);
        serve_r();
        compute();
        wait_for(3, 10, "req_r_g1");
        check("gi_g1", {28'd0, bus.OWMC_LOAD_INITIATOR_Group_Index}, 32'd1);
        serve_r();
        compute();
        wait_for(6, 10, "full_done");
        check("full_done_busy", {31'd0, bus.OWMC_LOAD_INITIATOR_Busy}, 32'd1);
        tick();
        check("full_after_done", {24'd0, outs()}, 32'h00);
        check("full_gi_clear", {28'd0, bus.OWMC_LOAD_INITIATOR_Group_Index}, 32'd0);
        check("full_ev_len", 32'(ev_q.size() - ev0), 32'd8);
        check("full_order", pack_ev(ev0), 32'o12345345);
        check("full_done_cnt", 32'(done_cnt - dn0), 32'd1);

        // Skip path, 1 group
        ev0 = ev_q.size();
        dn0 = done_cnt;
        cmd(4'd1, 1'b1);
        check("skip_reqr_outs", {24'd0, outs()}, 32'h44);
        serve_r();
        compute();
        wait_for(6, 10, "skip_done");
        tick();
        check("skip_order", pack_ev(ev0), 32'o345);
        check("skip_ev_len", 32'(ev_q.size() - ev0), 32'd3);
        check("skip_done_cnt", 32'(done_cnt - dn0), 32'd1);

        // Zero groups, weights loaded
        ev0 = ev_q.size();
        dn0 = done_cnt;
        cmd(4'd0, 1'b0);
        serve_w();
        wait_for(6, 4, "zero_w_done");
        tick();
        check("zero_w_order", pack_ev(ev0), 32'o12);
        check("zero_w_done_cnt", 32'(done_cnt - dn0), 32'd1);

        // Zero groups, weights skipped: Done within 2 cycles, no traffic
        ev0 = ev_q.size();
        dn0 = done_cnt;
        cmd(4'd0, 1'b1);
        wait_for(6, 1, "zero_skip_done");
        tick();
        tick();
        check("zero_skip_ev_len", 32'(ev_q.size() - ev0), 32'd0);
        check("zero_skip_done_cnt", 32'(done_cnt - dn0), 32'd1);
        check("zero_skip_idle", {24'd0, outs()}, 32'h00);

        // Four-phase: Already held 5 cycles after Ok
        cmd(4'd1, 1'b1);
        wait_for(3, 10, "fp_req_r");
        tick();
        tick();
        bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already = 1'b1;
        wait_for(4, 10, "fp_ok_r");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fp_ok_held", {31'd0, bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok}, 32'd1);
            check("fp_no_cmp", {31'd0, bus.OWMC_LOAD_INITIATOR_Compute_Start}, 32'd0);
        end
        bus.OWMC_LOAD_INITIATOR_Loading_Regs_Already = 1'b0;
        compute();
        wait_for(6, 10, "fp_done");
        tick();

        // Timeout in REQ_R (TIMEOUT_CYCLES=8): Error on the 9th cycle after entry
        cmd(4'd1, 1'b1);
        check("tmo_c1_reqr", {31'd0, bus.OWMC_LOAD_INITIATOR_Start_Loading_Regs}, 32'd1);
        repeat (7) tick();
        check("tmo_c8_outs", {24'd0, outs()}, 32'h44);
        tick();
        check("tmo_c9_outs", {24'd0, outs()}, 32'h01);
        bus.OWMC_LOAD_INITIATOR_Cmd_Start = 1'b1;
        tick();
        bus.OWMC_LOAD_INITIATOR_Cmd_Start = 1'b0;
        tick();
        check("err_ignores_start", {24'd0, outs()}, 32'h01);
        bus.OWMC_LOAD_INITIATOR_Err_Clear = 1'b1;
        tick();
        bus.OWMC_LOAD_INITIATOR_Err_Clear = 1'b0;
        check("err_clear_outs", {24'd0, outs()}, 32'h00);
        check("err_clear_gi", {28'd0, bus.OWMC_LOAD_INITIATOR_Group_Index}, 32'd0);

        // Asynchronous reset in CMP_WAIT of group 1, then a fresh start
        cmd(4'd2, 1'b1);
        serve_r();
        compute();
        serve_r();
        wait_for(5, 10, "rst_cmp_start");
        tick();
        check("rst_pre_outs", {24'd0, outs()}, 32'h04);
        check("rst_pre_gi", {28'd0, bus.OWMC_LOAD_INITIATOR_Group_Index}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outs", {24'd0, outs()}, 32'h00);
        check("rst_async_gi", {28'd0, bus.OWMC_LOAD_INITIATOR_Group_Index}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        cmd(4'd1, 1'b0);
        check("restart_reqw", {24'd0, outs()}, 32'h84);

        check("exclusivity", 32'(viol_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/owmc_load_initiator.md
Name: owmc_load_initiator

Overview:
- Initiator side of the on-chip weight memory controller handshake.
- On a host command it requests one bulk weight load into weight RAM, then N weight-register loads. Each register load is followed by one compute pass on the PE array.
- It confirms each completion back to the controller and reports done or error to the host.
- Sits between the host command interface and the weight memory controller.

Parameters:
- GROUP_W, 4, width of the filter-group count and index.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles for any single handshake wait state.
- TMO_W, 11, width of the watchdog counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- OWMC_LOAD_INITIATOR_Clk  in  1  clock; all state updates on rising edge.
- OWMC_LOAD_INITIATOR_Reset  in  1  asynchronous, active-high reset.
- OWMC_LOAD_INITIATOR_Cmd_Start  in  1  host start pulse.
- OWMC_LOAD_INITIATOR_Cmd_Num_Groups  in  GROUP_W  number of register-load/compute groups; sampled on accepted start.
- OWMC_LOAD_INITIATOR_Cmd_Skip_Weights  in  1  weights already resident; skip the bulk load; sampled on accepted start.
- OWMC_LOAD_INITIATOR_Err_Clear  in  1  leaves ERROR.
- OWMC_LOAD_INITIATOR_Loading_Weights_Already  in  1  controller reports bulk load complete.
- OWMC_LOAD_INITIATOR_Loading_Regs_Already  in  1  controller reports register load complete.
- OWMC_LOAD_INITIATOR_Compute_Done  in  1  PE array pass finished.
- OWMC_LOAD_INITIATOR_Start_Loading_Weights  out  1  request bulk weight load.
- OWMC_LOAD_INITIATOR_Start_Loading_Regs  out  1  request register load.
- OWMC_LOAD_INITIATOR_Loading_Weights_Already_Ok  out  1  confirmation for the bulk load.
- OWMC_LOAD_INITIATOR_Loading_Regs_Already_Ok  out  1  confirmation for the register load.
- OWMC_LOAD_INITIATOR_Compute_Start  out  1  one-cycle compute pulse.
- OWMC_LOAD_INITIATOR_Busy  out  1  high in every state except IDLE and ERROR.
- OWMC_LOAD_INITIATOR_Done  out  1  one-cycle completion pulse.
- OWMC_LOAD_INITIATOR_Error  out  1  watchdog expired.
- OWMC_LOAD_INITIATOR_Group_Index  out  GROUP_W  current group, 0-based.

Behaviour:
- Reset:
  - State is IDLE.
  - Every output is 0, Group_Index = 0, watchdog = 0, latched count = 0.
  - Reset asserted mid-sequence drops all requests and confirmations immediately (asynchronous).
- Outputs are Moore-decoded from the state register; the only other registered output is Group_Index. Any state change is visible one cycle after the causing input is sampled.
- IDLE:
  - Cmd_Start=1 latches Num_Groups and Skip_Weights.
  - Next state is REQ_R if Skip_Weights=1, otherwise REQ_W.
  - Cmd_Start outside IDLE is ignored.
- REQ_W: Start_Loading_Weights=1. On Loading_Weights_Already=1, go to ACK_W.
- ACK_W:
  - Start_Loading_Weights=0, Loading_Weights_Already_Ok=1.
  - Held until Loading_Weights_Already=0 (four-phase handshake).
  - Then go to DONE if count=0, otherwise to REQ_R.
- REQ_R: Start_Loading_Regs=1. On Loading_Regs_Already=1, go to ACK_R.
- ACK_R: Loading_Regs_Already_Ok=1, held until Loading_Regs_Already=0, then go to CMP_PULSE.
- CMP_PULSE: Compute_Start=1 for exactly one cycle, then go to CMP_WAIT.
- CMP_WAIT:
  - On Compute_Done=1: if Group_Index = count-1, go to DONE.
  - Otherwise increment Group_Index and go to REQ_R.
  - Compute_Done in any other state is ignored.
- DONE: Done=1 for one cycle, Group_Index cleared to 0, then go to IDLE.
- Skip_Weights=1 with count=0: go straight to DONE with no controller traffic.
- A request and its confirmation are never high in the same cycle.
  - Start_Loading_Weights and Start_Loading_Regs are never both high.
- Watchdog:
  - Cleared on every state entry.
  - Increments in REQ_W, ACK_W, REQ_R and ACK_R only; CMP_WAIT is unbounded.
  - When it reaches TIMEOUT_CYCLES-1 with the awaited condition still false, go to ERROR next cycle.
  - If the condition is true in that same cycle, the normal transition wins.
- ERROR:
  - Error=1 and all handshake outputs 0.
  - Err_Clear=1 returns to IDLE with Group_Index=0.
  - Cmd_Start is ignored while in ERROR.
- Counter arithmetic: Group_Index is unsigned GROUP_W bits. Maximum count is 2^GROUP_W-1, so no wrap is reachable.

Test Plan:
- Full sequence: Num_Groups=2, Skip=0. Controller model raises Already 3 cycles after each request and drops it 1 cycle after Ok.
  - Required order: Start_W, Ok_W, Start_R, Ok_R, Compute_Start, Start_R, Ok_R, Compute_Start.
  - Group_Index goes 0 then 1; one Done pulse; Busy falls on the cycle after Done.
- Skip path: Skip=1, Num_Groups=1 → Start_Loading_Weights never asserts; one register load, one compute, Done.
- Zero groups: Skip=0, Num_Groups=0 → one weight handshake, then Done. Skip=1, Num_Groups=0 → Done 2 cycles after Cmd_Start with no requests.
- Timeout: TIMEOUT_CYCLES=8, controller never responds in REQ_R → Error=1 on the 9th cycle after REQ_R entry, Start_Loading_Regs=0. Err_Clear → IDLE, Error=0.
- Four-phase check: hold Loading_Regs_Already high for 5 cycles after Ok → Ok stays high all 5 cycles; no Compute_Start until Already=0.
- Disturbances:
  - Cmd_Start pulsed mid-sequence → ignored.
  - Reset asserted in CMP_WAIT → all outputs 0 asynchronously; a fresh Cmd_Start restarts at REQ_W.
